avl_ram_slave: RTL and testbench

- Avalon-MM responder: a single-port on-chip RAM that answers read and write transfers from one slave-side port of the n-to-n interconnect.
- Fixed, parameterised read latency and a programmable number of wait states per transfer.
- Lets the bus fabric be exercised against realistic slave timing. It also serves as the default instruction/data memory behind the interconnect.

---
 rtl/avl_pkg.sv | 12 +
 rtl/avl_ram_core.sv | 28 ++
 rtl/avl_ram_slave.sv | 87 ++++++++
 tb/tb_avl_ram_slave.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/avl_pkg.sv
// Shared Avalon-MM widths and payload types for the RAM responder.
package avl_pkg;

  localparam int unsigned AVL_ADDR_W = 32;
  localparam int unsigned AVL_DATA_W = 32;
  localparam int unsigned AVL_BE_W   = 4;

  typedef logic [AVL_ADDR_W-1:0] avl_addr_t;
  typedef logic [AVL_DATA_W-1:0] avl_data_t;
  typedef logic [AVL_BE_W-1:0]   avl_be_t;

endpackage

// File: rtl/avl_ram_core.sv
// Single-port synchronous RAM: byte-lane write, registered read-first output.
module avl_ram_core
  import avl_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  avl_be_t          be,
  input  logic [IDX_W-1:0] idx,
  input  avl_data_t        wdata,
  output avl_data_t        rdata
);

  avl_data_t mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(AVL_BE_W); i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/avl_ram_slave.sv
// Avalon-MM RAM responder with programmable wait states and a fixed
// read-latency pipeline in front of a single-port RAM.
module avl_ram_slave
  import avl_pkg::*;
#(
  parameter int unsigned DEPTH        = 4096,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned WAIT_STATES  = 0
) (
  input  logic      clk,
  input  logic      rest,
  input  avl_addr_t avl_address,
  input  avl_be_t   avl_byte_en,
  input  logic      avl_read,
  input  logic      avl_write,
  input  avl_data_t avl_writedata,
  output logic      avl_waitrequest,
  output avl_data_t avl_readdata,
  output logic      avl_readdatavalid,
  output logic      err_sticky
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned WS_W  = 4;
  localparam logic [WS_W-1:0] WS_LIM = WS_W'(WAIT_STATES);

  logic            req;
  logic            accept;
  logic            wr_acc;
  logic            rd_acc;
  logic [WS_W-1:0] ws_q;
  logic [WS_W-1:0] ws_d;
  avl_data_t       ram_rdata;

  logic [READ_LATENCY-1:0] vld_q;
  avl_data_t               pipe_q [READ_LATENCY];

  // Byte offset and aliased upper address bits carry no meaning here.
  logic unused_addr;
  assign unused_addr = ^{avl_address[1:0], avl_address[AVL_ADDR_W-1:2+IDX_W]};

  // Acceptance and wait-state counting; a read together with a write is a write.
  always_comb begin
    req             = avl_read | avl_write;
    avl_waitrequest = rest | (req & (ws_q != WS_LIM));
    accept          = req & ~avl_waitrequest;
    wr_acc          = accept & avl_write;
    rd_acc          = accept & avl_read & ~avl_write;
    ws_d            = '0;
    if (req && !accept) ws_d = ws_q + WS_W'(1);
  end

  avl_ram_core #(.DEPTH(DEPTH)) u_core (
    .clk   (clk),
    .we    (wr_acc),
    .be    (avl_byte_en),
    .idx   (avl_address[2 +: IDX_W]),
    .wdata (avl_writedata),
    .rdata (ram_rdata)
  );

  // Stage 0 is the RAM output register; pipe_q[0] only holds it between reads.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      ws_q       <= '0;
      vld_q      <= '0;
      err_sticky <= 1'b0;
      for (int i = 0; i < int'(READ_LATENCY); i++) pipe_q[i] <= '0;
    end else begin
      ws_q     <= ws_d;
      vld_q[0] <= rd_acc;
      if (vld_q[0]) pipe_q[0] <= ram_rdata;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) pipe_q[i] <= (i == 1) ? ram_rdata : pipe_q[i-1];
      end
      if (avl_read && avl_write) err_sticky <= 1'b1;
    end
  end

  always_comb begin
    avl_readdatavalid = vld_q[READ_LATENCY-1];
    if (READ_LATENCY == 1) avl_readdata = vld_q[0] ? ram_rdata : pipe_q[0];
    else                   avl_readdata = pipe_q[READ_LATENCY-1];
  end

endmodule

// File: tb/tb_avl_ram_slave.sv
// Directed bench for avl_ram_slave: four instances cover the latency and
// wait-state configurations side by side on one clock and reset.
module tb_avl_ram_slave;
  import avl_pkg::*;

  localparam int N = 4;

  logic      clk = 1'b0;
  logic      rest;
  avl_addr_t addr  [N];
  avl_data_t wdata [N];
  avl_data_t rdata [N];
  avl_be_t   ben   [N];
  logic      rd_s  [N];
  logic      wr_s  [N];
  logic      wreq  [N];
  logic      rdv   [N];
  logic      err   [N];

  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  int        pulses [N];
  avl_data_t cap  [N][16];
  int        vcyc [N][16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: WS0/L1, 1: WS3/L1, 2: WS0/L3, 3: WS0/L4
  for (genvar g = 0; g < N; g++) begin : g_dut
    avl_ram_slave #(
      .DEPTH        (64),
      .READ_LATENCY (g == 2 ? 3 : (g == 3 ? 4 : 1)),
      .WAIT_STATES  (g == 1 ? 3 : 0)
    ) u_dut (
      .clk               (clk),
      .rest              (rest),
      .avl_address       (addr[g]),
      .avl_byte_en       (ben[g]),
      .avl_read          (rd_s[g]),
      .avl_write         (wr_s[g]),
      .avl_writedata     (wdata[g]),
      .avl_waitrequest   (wreq[g]),
      .avl_readdata      (rdata[g]),
      .avl_readdatavalid (rdv[g]),
      .err_sticky        (err[g])
    );
  end

  // Record every readdatavalid pulse with its data and cycle stamp.
  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (rdv[g] === 1'b1) begin
        cap[g][pulses[g] % 16]  = rdata[g];
        vcyc[g][pulses[g] % 16] = cyc;
        pulses[g]++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Hold the current request until accepted; returns at the negedge after acceptance.
  task automatic waitaccept(input int g, output int waits);
    waits = 0;
    #1;
    while (wreq[g] === 1'b1 && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
    end
    chk("accept_timeout", 32'(waits >= 50), 32'd0);
    @(negedge clk);
  endtask

  task automatic wr(input int g, input avl_addr_t a, input avl_data_t d,
                    input avl_be_t be, output int waits);
    addr[g] = a; wdata[g] = d; ben[g] = be; wr_s[g] = 1'b1;
    waitaccept(g, waits);
    wr_s[g] = 1'b0;
  endtask

  task automatic rd(input int g, input avl_addr_t a, output int waits);
    addr[g] = a; rd_s[g] = 1'b1;
    waitaccept(g, waits);
    rd_s[g] = 1'b0;
  endtask

  initial begin
    int w, w1, w2, p, a;
    avl_data_t vals [4];
    vals[0] = 32'hA0A0_0000; vals[1] = 32'hA1A1_1111;
    vals[2] = 32'hA2A2_2222; vals[3] = 32'hA3A3_3333;

    rest = 1'b1;
    for (int g = 0; g < N; g++) begin
      addr[g] = '0; wdata[g] = '0; ben[g] = '0;
      rd_s[g] = 1'b0; wr_s[g] = 1'b0; pulses[g] = 0;
    end
    tick(); tick(); #1;
    chk("rst_waitreq", 32'(wreq[0]), 32'd1);
    chk("rst_rdv", 32'(rdv[0]), 32'd0);
    chk("rst_rdata", rdata[0], 32'd0);
    chk("rst_rdata_l4", rdata[3], 32'd0);
    chk("rst_err", 32'(err[0]), 32'd0);
    rest = 1'b0;
    tick();

    // Basic write/read, zero wait states, latency 1
    wr(0, 32'h10, 32'hDEADBEEF, 4'hF, w);
    chk("t1_wr_waits", 32'(w), 32'd0);
    rd(0, 32'h10, w);
    chk("t1_rd_waits", 32'(w), 32'd0);
    chk("t1_rdv", 32'(rdv[0]), 32'd1);
    chk("t1_rdata", rdata[0], 32'hDEADBEEF);
    tick();
    chk("t1_rdv_drop", 32'(rdv[0]), 32'd0);
    chk("t1_rdata_hold", rdata[0], 32'hDEADBEEF);
    rd(0, 32'h113, w);
    chk("t1_alias", rdata[0], 32'hDEADBEEF);

    // Byte enables, including an all-zero enable no-op
    wr(0, 32'h20, 32'h11223344, 4'hF, w);
    wr(0, 32'h20, 32'hAABBCCDD, 4'b0101, w);
    rd(0, 32'h20, w);
    chk("t2_be", rdata[0], 32'h11BB33DD);
    wr(0, 32'h20, 32'hFFFFFFFF, 4'h0, w);
    rd(0, 32'h20, w);
    chk("t2_be0", rdata[0], 32'h11BB33DD);

    // Three wait states per transfer, back-to-back reads
    wr(1, 32'h20, 32'h12345678, 4'hF, w);
    chk("t3_wr_waits", 32'(w), 32'd3);
    #2; p = pulses[1];
    addr[1] = 32'h20; rd_s[1] = 1'b1;
    waitaccept(1, w1);
    waitaccept(1, w2);
    rd_s[1] = 1'b0;
    chk("t3_rd1_waits", 32'(w1), 32'd3);
    chk("t3_rd2_waits", 32'(w2), 32'd3);
    tick(); tick(); #2;
    chk("t3_pulses", 32'(pulses[1] - p), 32'd2);
    chk("t3_data", cap[1][(pulses[1] - 1) % 16], 32'h12345678);

    // Latency 3 pipelined reads
    for (int k = 0; k < 4; k++) wr(2, 32'(4 * k), vals[k], 4'hF, w);
    #2; p = pulses[2];
    addr[2] = 32'h0; rd_s[2] = 1'b1;
    tick(); a = cyc;
    addr[2] = 32'h4; tick();
    addr[2] = 32'h8; tick();
    addr[2] = 32'hC; tick();
    rd_s[2] = 1'b0;
    repeat (4) tick();
    #2;
    chk("t4_pulses", 32'(pulses[2] - p), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t4_data", cap[2][(p + k) % 16], vals[k]);
      chk("t4_cycle", 32'(vcyc[2][(p + k) % 16]), 32'(a + 2 + k));
    end
    // Write then immediate read of the same word
    addr[2] = 32'h4; wdata[2] = 32'hB4B4B4B4; ben[2] = 4'hF; wr_s[2] = 1'b1;
    tick();
    wr_s[2] = 1'b0; rd_s[2] = 1'b1;
    tick();
    rd_s[2] = 1'b0;
    repeat (4) tick();
    #2;
    chk("t4_raw", cap[2][(p + 4) % 16], 32'hB4B4B4B4);
    // Write landing while a read of the same word is in flight
    addr[2] = 32'h8; rd_s[2] = 1'b1;
    tick();
    rd_s[2] = 1'b0; wdata[2] = 32'hC8C8C8C8; wr_s[2] = 1'b1;
    tick();
    wr_s[2] = 1'b0;
    repeat (4) tick();
    #2;
    chk("t4_inflight", cap[2][(p + 5) % 16], vals[2]);
    rd(2, 32'h8, w);
    repeat (3) tick();
    #2;
    chk("t4_after", cap[2][(p + 6) % 16], 32'hC8C8C8C8);
    chk("t4_total", 32'(pulses[2] - p), 32'd7);

    // Simultaneous read and write
    p = pulses[0];
    addr[0] = 32'h30; wdata[0] = 32'h5A5A5A5A; ben[0] = 4'hF;
    rd_s[0] = 1'b1; wr_s[0] = 1'b1;
    tick();
    rd_s[0] = 1'b0; wr_s[0] = 1'b0;
    repeat (3) tick();
    #2;
    chk("t5_no_rdv", 32'(pulses[0] - p), 32'd0);
    chk("t5_err", 32'(err[0]), 32'd1);
    chk("t5_err_other", 32'(err[1]), 32'd0);
    rd(0, 32'h30, w);
    chk("t5_data", rdata[0], 32'h5A5A5A5A);
    tick();
    chk("t5_err_sticky", 32'(err[0]), 32'd1);

    // Reset with reads in flight and a write presented during reset
    #2; p = pulses[3];
    addr[3] = 32'h0; rd_s[3] = 1'b1;
    tick();
    addr[3] = 32'h4;
    tick();
    rest = 1'b1;
    addr[0] = 32'h10; wdata[0] = 32'h0; ben[0] = 4'hF; wr_s[0] = 1'b1;
    #1;
    chk("t6_waitreq_rst", 32'(wreq[3]), 32'd1);
    chk("t6_waitreq_rst0", 32'(wreq[0]), 32'd1);
    tick();
    rest = 1'b0; rd_s[3] = 1'b0; wr_s[0] = 1'b0;
    repeat (6) tick();
    #2;
    chk("t6_no_rdv", 32'(pulses[3] - p), 32'd0);
    chk("t6_rdv_low", 32'(rdv[3]), 32'd0);
    chk("t6_err_clr", 32'(err[0]), 32'd0);
    rd(0, 32'h10, w);
    chk("t6_wr_blocked", rdata[0], 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
